ddr_input_capture: RTL and testbench



---
 rtl/adc_pkg.sv | 15 +
 rtl/ddr_in_bit.sv | 54 +++++
 rtl/ddr_input_capture.sv | 46 ++++
 tb/tb_ddr_input_capture.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// ----------------------------------------------------------------------------
// adc_pkg
// Shared constants for the ADC LVDS front end.
//   ADC_LANES       : number of serial data lanes coming off the ADC.
//   ADC_LANE_INVERT : per-lane polarity correction. A 1 means the board swaps
//                     P/N on that lane, so the captured bit must be inverted.
//                     Lanes 2 and 6 are routed straight; all others swapped.
// ----------------------------------------------------------------------------
package adc_pkg;

    localparam int unsigned ADC_LANES = 8;

    localparam logic [ADC_LANES-1:0] ADC_LANE_INVERT = 8'b1011_1011;

endpackage : adc_pkg

// File: rtl/ddr_in_bit.sv
// ----------------------------------------------------------------------------
// ddr_in_bit
// Single-lane DDR input capture cell.
// Samples the lane on both clock edges and presents the pair aligned to the
// rising edge. The falling-edge sample is re-registered on the rising edge so
// both outputs change together and stay stable for a full bit-clock period.
//
// Ports:
//   inclock  in   bit clock (both edges sample, outputs update on rising)
//   reset_n  in   asynchronous active-low reset, clears all state
//   din      in   serial lane bit
//   dout_h   out  sample taken at the most recent rising edge
//   dout_l   out  sample taken at the falling edge just before that rising edge
// ----------------------------------------------------------------------------
module ddr_in_bit #(
    parameter logic INVERT = 1'b0
) (
    input  logic inclock,
    input  logic reset_n,
    input  logic din,
    output logic dout_h,
    output logic dout_l
);

    logic cap_d;     // polarity-corrected lane bit, shared by both edges
    logic pos_q;     // rising-edge capture
    logic neg_q;     // falling-edge capture
    logic neg_sync;  // neg_q moved into the rising-edge domain

    assign cap_d = din ^ INVERT;

    always_ff @(negedge inclock or negedge reset_n) begin
        if (!reset_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= cap_d;
        end
    end

    always_ff @(posedge inclock or negedge reset_n) begin
        if (!reset_n) begin
            pos_q    <= 1'b0;
            neg_sync <= 1'b0;
        end else begin
            pos_q    <= cap_d;
            neg_sync <= neg_q;
        end
    end

    // Outputs come straight from flops: no combinational path from din.
    assign dout_h = pos_q;
    assign dout_l = neg_sync;

endmodule : ddr_in_bit

// File: rtl/ddr_input_capture.sv
// ----------------------------------------------------------------------------
// ddr_input_capture
// Double-data-rate input capture register for the ADC LVDS lanes.
// Each lane is sampled on both edges of inclock; the rising-edge sample is
// presented on dataout_h and the preceding falling-edge sample on dataout_l,
// both updating on the rising edge only. The l bit of a pair is therefore
// half a cycle older than its h bit.
//
// Parameters:
//   WIDTH        number of lanes
//   INVERT_MASK  per-lane polarity correction (bit i = 1 inverts lane i)
//
// Ports:
//   inclock    in   bit clock
//   reset_n    in   asynchronous active-low reset
//   datain     in   DDR serial data, one bit per lane
//   dataout_h  out  rising-edge samples
//   dataout_l  out  falling-edge samples preceding that rising edge
// ----------------------------------------------------------------------------
module ddr_input_capture
    import adc_pkg::*;
#(
    parameter int unsigned           WIDTH       = ADC_LANES,
    parameter logic [WIDTH-1:0]      INVERT_MASK = '0
) (
    input  logic             inclock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout_h,
    output logic [WIDTH-1:0] dataout_l
);

    // Lanes are independent: one capture cell each, with its own polarity bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ddr_in_bit #(
            .INVERT (INVERT_MASK[i])
        ) u_bit (
            .inclock (inclock),
            .reset_n (reset_n),
            .din     (datain[i]),
            .dout_h  (dataout_h[i]),
            .dout_l  (dataout_l[i])
        );
    end

endmodule : ddr_input_capture

// File: tb/tb_ddr_input_capture.sv
// ----------------------------------------------------------------------------
// tb_ddr_input_capture
// Two instances share clock, reset and data: u_plain has no polarity mask,
// u_inv uses the board mask. Expected {h,l} pairs for both are queued when
// the stimulus is driven and popped once the rising edge has produced them.
// ----------------------------------------------------------------------------
module tb_ddr_input_capture;
  import adc_pkg::*;

  localparam logic [7:0] MASK_INV = 8'hBB;

  logic       inclock;
  logic       reset_n;
  logic [7:0] datain;
  logic [7:0] h0, l0, h1, l1;

  // expected word layout: {h_plain, l_plain, h_inv, l_inv}
  logic [31:0] exp_q[$];
  logic [31:0] cur_exp;

  int n_checks;
  int n_pass;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial inclock = 1'b0;
  always #5 inclock = ~inclock;

  ddr_input_capture #(
    .WIDTH       (8),
    .INVERT_MASK (8'h00)
  ) u_plain (
    .inclock   (inclock),
    .reset_n   (reset_n),
    .datain    (datain),
    .dataout_h (h0),
    .dataout_l (l0)
  );

  ddr_input_capture #(
    .WIDTH       (ADC_LANES),
    .INVERT_MASK (ADC_LANE_INVERT)
  ) u_inv (
    .inclock   (inclock),
    .reset_n   (reset_n),
    .datain    (datain),
    .dataout_h (h1),
    .dataout_l (l1)
  );

  // ---------------- scoreboard compare ----------------
  task automatic check_pair(input string tag, input logic [31:0] e);
    n_checks++;
    assert ({h0, l0, h1, l1} === e) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed h=%h l=%h inv_h=%h inv_l=%h expected h=%h l=%h inv_h=%h inv_l=%h",
             tag, h0, l0, h1, l1, e[31:24], e[23:16], e[15:8], e[7:0]);
    end
  endtask

  function automatic logic [31:0] pair_of(input logic [7:0] rv, input logic [7:0] fv);
    return {rv, fv, rv ^ MASK_INV, fv ^ MASK_INV};
  endfunction

  // ---------------- driver ----------------
  // Entered just after a rising edge. Presents fv across the falling edge and
  // rv across the next rising edge; checks outputs held mid-cycle, then the
  // new pair after the rising edge.
  task automatic cycle(input string tag, input logic [7:0] fv, input logic [7:0] rv);
    datain = fv;
    @(negedge inclock); #1;
    check_pair({tag, "_hold"}, cur_exp);
    datain = rv;
    exp_q.push_back(pair_of(rv, fv));
    @(posedge inclock); #1;
    cur_exp = exp_q.pop_front();
    check_pair(tag, cur_exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] rv;
    logic [7:0] fv;
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    cur_exp  = '0;

    // Reset held with all-ones data: everything reads zero, mask or not.
    reset_n = 1'b0;
    datain  = 8'hFF;
    repeat (3) begin
      @(posedge inclock); #1;
      check_pair("reset_rise", 32'h0);
      @(negedge inclock); #1;
      check_pair("reset_fall", 32'h0);
    end

    // Release after a falling edge: first pair has l = 0 in both instances.
    reset_n = 1'b1;
    datain  = 8'h96;
    exp_q.push_back({8'h96, 8'h00, 8'h96 ^ MASK_INV, 8'h00});
    @(posedge inclock); #1;
    cur_exp = exp_q.pop_front();
    check_pair("first_after_reset", cur_exp);

    // Basic DDR pair.
    cycle("basic_ddr", 8'hA5, 8'h3C);

    // Alternating pattern, steady state with mid-cycle hold checks.
    repeat (3) cycle("alternate", 8'hAA, 8'h55);

    // Zero data: inverted instance shows the mask on both outputs.
    repeat (2) cycle("polarity_zero", 8'h00, 8'h00);

    // Lane independence: walking one on falling edges only.
    for (int i = 0; i < 8; i++) begin
      fv = 8'h01 << i;
      cycle("walk_one", fv, 8'h00);
    end

    // Random streaming.
    repeat (6) begin
      fv = 8'($urandom_range(0, 255));
      rv = 8'($urandom_range(0, 255));
      cycle("random", fv, rv);
    end

    // Asynchronous reset mid-cycle, between a rising and a falling edge.
    datain = 8'($urandom_range(0, 255));
    #1 reset_n = 1'b0;
    #1;
    cur_exp = '0;
    check_pair("async_reset_now", cur_exp);
    @(negedge inclock); #1;
    check_pair("async_reset_fall", cur_exp);
    #1 reset_n = 1'b1;
    rv = 8'($urandom_range(0, 255));
    datain = rv;
    exp_q.push_back({rv, 8'h00, rv ^ MASK_INV, 8'h00});
    @(posedge inclock); #1;
    cur_exp = exp_q.pop_front();
    check_pair("post_reset_first", cur_exp);

    repeat (3) begin
      fv = 8'($urandom_range(0, 255));
      rv = 8'($urandom_range(0, 255));
      cycle("post_reset_stream", fv, rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ddr_input_capture
